// File: rtl/preg_free_list_ctrl_if.sv
// Rename/retire-facing signals of the physical-register free list.
// master = rename/retire side, slave = free-list controller.
interface preg_free_list_ctrl_if #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned FL_DEPTH  = 32
);
    localparam int unsigned PW = $clog2(NUM_PREGS);
    localparam int unsigned CW = $clog2(FL_DEPTH + 1);

    logic          alloc_req_1;
    logic          alloc_req_2;
    logic          alloc_gnt_1;
    logic          alloc_gnt_2;
    logic [PW-1:0] pd_1;
    logic [PW-1:0] pd_2;
    logic          stall_o;
    logic          rt_flag_1;
    logic [PW-1:0] fp_i_1;
    logic          rt_flag_2;
    logic [PW-1:0] fp_i_2;
    logic          ready_o;
    logic [CW-1:0] free_cnt_o;
    logic          err_ovf_o;

    modport master (
        output alloc_req_1, alloc_req_2, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
        input  alloc_gnt_1, alloc_gnt_2, pd_1, pd_2, stall_o, ready_o,
               free_cnt_o, err_ovf_o
    );

    modport slave (
        input  alloc_req_1, alloc_req_2, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
        output alloc_gnt_1, alloc_gnt_2, pd_1, pd_2, stall_o, ready_o,
               free_cnt_o, err_ovf_o
    );
endinterface

// File: rtl/preg_free_list_ctrl.sv
// Circular free list of physical registers: 2 in-order grants to rename and
// 2 returns from retire per cycle, seeded with NUM_AREGS..NUM_PREGS-1 at reset.
module preg_free_list_ctrl #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS
) (
    input logic                  clk,
    input logic                  rst_n,
    preg_free_list_ctrl_if.slave fl
);
    localparam int unsigned PW = $clog2(NUM_PREGS);
    localparam int unsigned CW = $clog2(FL_DEPTH + 1);
    localparam int unsigned IW = $clog2(FL_DEPTH);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t        state;
    logic          ready_q;
    logic          err_q;
    logic [PW-1:0] mem [FL_DEPTH];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW-1:0] init_idx;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_after_pop;
    logic [CW-1:0] count_next;
    logic [1:0]    npop;
    logic [1:0]    npush;
    logic          gnt_1;
    logic          gnt_2;
    logic          acc_1;
    logic          acc_2;
    logic          ovf;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] x, input logic [1:0] n);
        logic [IW:0] s;
        s = {1'b0, x} + (IW+1)'(n);
        if (s >= (IW+1)'(FL_DEPTH))
            s = s - (IW+1)'(FL_DEPTH);
        return s[IW-1:0];
    endfunction

    always_comb begin
        gnt_1 = ready_q && fl.alloc_req_1 && (count != '0);
        gnt_2 = ready_q && fl.alloc_req_2 &&
                (fl.alloc_req_1 ? (gnt_1 && (count >= CW'(2))) : (count != '0));
        npop  = {1'b0, gnt_1} + {1'b0, gnt_2};
        // Capacity check sees this cycle's pops; freed pregs only become grantable next cycle.
        cnt_after_pop = count - CW'(npop);
        acc_1 = ready_q && fl.rt_flag_1 && (cnt_after_pop < CW'(FL_DEPTH));
        acc_2 = ready_q && fl.rt_flag_2 && ((cnt_after_pop + CW'(acc_1)) < CW'(FL_DEPTH));
        ovf   = (fl.rt_flag_1 && !acc_1) || (fl.rt_flag_2 && !acc_2);
        npush = {1'b0, acc_1} + {1'b0, acc_2};
        count_next = cnt_after_pop + CW'(npush);
    end

    assign fl.alloc_gnt_1 = gnt_1;
    assign fl.alloc_gnt_2 = gnt_2;
    assign fl.pd_1        = gnt_1 ? mem[head] : '0;
    assign fl.pd_2        = gnt_2 ? mem[wrap_add(head, {1'b0, gnt_1})] : '0;
    assign fl.stall_o     = !ready_q || (fl.alloc_req_1 && !gnt_1) || (fl.alloc_req_2 && !gnt_2);
    assign fl.ready_o     = ready_q;
    assign fl.free_cnt_o  = count;
    assign fl.err_ovf_o   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            head     <= '0;
            tail     <= '0;
            init_idx <= '0;
            count    <= '0;
        end else begin
            err_q <= err_q | ovf;
            case (state)
                S_INIT: begin
                    tail     <= wrap_add(tail, 2'd1);
                    count    <= count + CW'(1);
                    init_idx <= init_idx + IW'(1);
                    if (init_idx == IW'(FL_DEPTH - 1)) begin
                        state   <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                S_READY: begin
                    head  <= wrap_add(head, npop);
                    tail  <= wrap_add(tail, npush);
                    count <= count_next;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Storage carries no reset; INIT rewrites every entry before it can be read.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_idx] <= PW'(NUM_AREGS + 32'(init_idx));
        end else begin
            if (acc_1)
                mem[tail] <= fl.fp_i_1;
            if (acc_2)
                mem[acc_1 ? wrap_add(tail, 2'd1) : tail] <= fl.fp_i_2;
        end
    end
endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Directed bench for preg_free_list_ctrl: init, paired grants, exhaustion,
// same-cycle free without bypass, overflow, and mid-run reset.
module tb_preg_free_list_ctrl;
    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned failures;

    preg_free_list_ctrl_if #(.NUM_PREGS(64), .FL_DEPTH(32)) fl_if ();

    preg_free_list_ctrl #(.NUM_PREGS(64), .NUM_AREGS(32), .FL_DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic r1, input logic r2);
        fl_if.alloc_req_1 = r1;
        fl_if.alloc_req_2 = r2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_req(1'b0, 1'b0);
        fl_if.rt_flag_1 = 1'b0;
        fl_if.rt_flag_2 = 1'b0;
        fl_if.fp_i_1    = '0;
        fl_if.fp_i_2    = '0;

        // Reset state, with a request that must not be granted
        #2;
        set_req(1'b1, 1'b0);
        #1;
        chk("rst_ready", fl_if.ready_o, 0);
        chk("rst_cnt", fl_if.free_cnt_o, 0);
        chk("rst_err", fl_if.err_ovf_o, 0);
        chk("rst_gnt1", fl_if.alloc_gnt_1, 0);
        chk("rst_pd1", fl_if.pd_1, 0);
        chk("rst_stall", fl_if.stall_o, 1);
        #4 rst_n = 1'b1;

        // 1. INIT takes 32 cycles
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 30) begin
                chk("init_ready_c31", fl_if.ready_o, 0);
                chk("init_gnt1", fl_if.alloc_gnt_1, 0);
                chk("init_stall", fl_if.stall_o, 1);
                chk("init_cnt_c31", fl_if.free_cnt_o, 31);
            end
        end
        set_req(1'b0, 1'b0);
        #1;
        chk("init_ready", fl_if.ready_o, 1);
        chk("init_cnt", fl_if.free_cnt_o, 32);
        chk("init_err", fl_if.err_ovf_o, 0);
        chk("idle_stall", fl_if.stall_o, 0);

        // 2. First paired grant
        set_req(1'b1, 1'b1);
        #1;
        chk("t2_gnt1", fl_if.alloc_gnt_1, 1);
        chk("t2_gnt2", fl_if.alloc_gnt_2, 1);
        chk("t2_pd1", fl_if.pd_1, 32);
        chk("t2_pd2", fl_if.pd_2, 33);
        chk("t2_stall", fl_if.stall_o, 0);
        step();
        chk("t2_cnt", fl_if.free_cnt_o, 30);

        // 3. Drain to 1, then a pair can only be half granted
        for (int k = 0; k < 14; k++) begin
            #1;
            chk("t3_pd1", fl_if.pd_1, 34 + 2 * k);
            chk("t3_pd2", fl_if.pd_2, 35 + 2 * k);
            step();
        end
        chk("t3_cnt2", fl_if.free_cnt_o, 2);
        set_req(1'b1, 1'b0);
        #1;
        chk("t3_pd1_62", fl_if.pd_1, 62);
        step();
        chk("t3_cnt1", fl_if.free_cnt_o, 1);
        set_req(1'b1, 1'b1);
        #1;
        chk("t3_last_gnt1", fl_if.alloc_gnt_1, 1);
        chk("t3_last_pd1", fl_if.pd_1, 63);
        chk("t3_last_gnt2", fl_if.alloc_gnt_2, 0);
        chk("t3_last_pd2", fl_if.pd_2, 0);
        chk("t3_last_stall", fl_if.stall_o, 1);
        step();
        chk("t3_cnt0", fl_if.free_cnt_o, 0);
        set_req(1'b0, 1'b1);
        #1;
        chk("t3_empty_gnt2", fl_if.alloc_gnt_2, 0);
        chk("t3_empty_stall", fl_if.stall_o, 1);

        // 4. Free while empty: no same-cycle bypass
        set_req(1'b1, 1'b0);
        fl_if.rt_flag_1 = 1'b1; fl_if.fp_i_1 = 6'd40;
        fl_if.rt_flag_2 = 1'b1; fl_if.fp_i_2 = 6'd41;
        #1;
        chk("t4_nobypass_gnt1", fl_if.alloc_gnt_1, 0);
        chk("t4_nobypass_stall", fl_if.stall_o, 1);
        step();
        fl_if.rt_flag_1 = 1'b0;
        fl_if.rt_flag_2 = 1'b0;
        set_req(1'b1, 1'b1);
        #1;
        chk("t4_cnt", fl_if.free_cnt_o, 2);
        chk("t4_pd1", fl_if.pd_1, 40);
        chk("t4_pd2", fl_if.pd_2, 41);
        step();
        chk("t4_cnt0", fl_if.free_cnt_o, 0);

        // 5. Fill with 0..31, pop+push at full, then overflow
        set_req(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            fl_if.rt_flag_1 = 1'b1; fl_if.fp_i_1 = 6'(2 * k);
            fl_if.rt_flag_2 = 1'b1; fl_if.fp_i_2 = 6'(2 * k + 1);
            step();
        end
        fl_if.rt_flag_2 = 1'b0;
        fl_if.fp_i_1 = 6'd50;
        set_req(1'b1, 1'b0);
        #1;
        chk("t5_full_cnt", fl_if.free_cnt_o, 32);
        chk("t5_full_err", fl_if.err_ovf_o, 0);
        chk("t5_full_pd1", fl_if.pd_1, 0);
        step();
        chk("t5_swap_cnt", fl_if.free_cnt_o, 32);
        chk("t5_swap_err", fl_if.err_ovf_o, 0);
        set_req(1'b0, 1'b0);
        fl_if.fp_i_1 = 6'd5;
        step();
        fl_if.rt_flag_1 = 1'b0;
        chk("t5_ovf_err", fl_if.err_ovf_o, 1);
        chk("t5_ovf_cnt", fl_if.free_cnt_o, 32);
        step();
        chk("t5_err_sticky", fl_if.err_ovf_o, 1);

        // Order after drop: 1..31 then 50; pop 15 to reach 17
        set_req(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t5_pop_pd1", fl_if.pd_1, 1 + 2 * k);
            chk("t5_pop_pd2", fl_if.pd_2, 2 + 2 * k);
            step();
        end
        set_req(1'b1, 1'b0);
        #1;
        chk("t5_pop_pd15", fl_if.pd_1, 15);
        step();
        chk("t6_pre_cnt", fl_if.free_cnt_o, 17);

        // 6. Asynchronous reset mid-run, free during INIT flags overflow
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", fl_if.ready_o, 0);
        chk("t6_rst_cnt", fl_if.free_cnt_o, 0);
        chk("t6_rst_err", fl_if.err_ovf_o, 0);
        chk("t6_rst_gnt1", fl_if.alloc_gnt_1, 0);
        chk("t6_rst_pd1", fl_if.pd_1, 0);
        #1 rst_n = 1'b1;
        fl_if.rt_flag_1 = 1'b1; fl_if.fp_i_1 = 6'd7;
        for (int i = 0; i < 32; i++) begin
            step();
            fl_if.rt_flag_1 = 1'b0;
        end
        #1;
        chk("t6_ready", fl_if.ready_o, 1);
        chk("t6_cnt", fl_if.free_cnt_o, 32);
        chk("t6_init_err", fl_if.err_ovf_o, 1);
        chk("t6_gnt1", fl_if.alloc_gnt_1, 1);
        chk("t6_pd1", fl_if.pd_1, 32);
        step();
        chk("t6_cnt31", fl_if.free_cnt_o, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
